host_cmd_decoder: RTL
=====================

# host_cmd_decoder

Host-to-FPGA command parser for the radar gateware. Consumes the byte stream from the ft245 read FIFO (`rden`/`rddata`/`rdfifo_empty`), frames it into fixed-length packets, and validates each packet. Good packets become register-write strobes or start/stop pulses for `control` and configuration logic. Runs in the 40 MHz `clk_i` domain; the ft245 read FIFO provides the clock crossing.

## Interface
Parameters:
- `REG_ADDR_WIDTH`, 3: register address width; register count is `1<<REG_ADDR_WIDTH`.
- `REG_WIDTH`, 32: register data width; always 4 payload bytes.
- `TIMEOUT_CYCLES`, 4096: idle cycles allowed mid-frame before the parser aborts.

Ports:
- `clk`, in, 1: system clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `rdfifo_empty`, in, 1: ft245 read FIFO empty.
- `rden`, out, 1: read strobe to ft245 read FIFO.
- `rddata`, in, 8: FIFO byte, valid the cycle after `rden`.
- `reg_wr_en`, out, 1: one-cycle register write strobe.
- `reg_addr`, out, REG_ADDR_WIDTH: write address.
- `reg_wr_data`, out, REG_WIDTH: write data.
- `start_o`, out, 1: one-cycle acquisition start pulse.
- `stop_o`, out, 1: one-cycle acquisition stop pulse.
- `frame_err`, out, 1: one-cycle pulse on any rejected frame.
- `err_count`, out, 8: saturating rejected-frame count.
- `busy`, out, 1: high while a frame is partially received.

## Operation
- Frame format, in order:
  - sync byte `0xA5`.
  - cmd byte: `[7:4]` opcode, `[3:0]` address.
  - 4 data bytes, MSB first.
  - checksum byte: XOR of the cmd byte and the 4 data bytes.
- Opcodes:
  - `0x1`: write register.
  - `0x2`: start.
  - `0x3`: stop.
  - Any other opcode is an error.
- Read side: `rden = !rdfifo_empty`. Registered `byte_valid` is `rden` delayed by one cycle. The parser never stalls, so one byte per cycle is sustained.
- State machine:
  - IDLE: a `byte_valid` byte of `0xA5` moves to CMD. Any other byte is discarded silently, with no error.
  - CMD: latch the cmd byte, seed the running XOR, move to DATA.
  - DATA: shift each byte into the data register; a 2-bit counter goes 0..3, then move to CHK.
  - CHK: compare the byte with the running XOR, execute or reject, return to IDLE.
- A `0xA5` byte inside CMD, DATA or CHK is treated as ordinary data. There is no resync.
- Execution on a good checksum:
  - Opcode 1 with address < `1<<REG_ADDR_WIDTH`: `reg_wr_en` pulse with `reg_addr` and `reg_wr_data`.
  - Opcode 2: `start_o` pulse.
  - Opcode 3: `stop_o` pulse.
  - Address bits above `REG_ADDR_WIDTH` set on opcode 1 cause an error.
- Rejection causes: bad checksum, unknown opcode, out-of-range address, or timeout. Each gives a `frame_err` pulse and `err_count` +1, saturating at 255. No other output fires.
- Timeout: while the state is not IDLE, a counter increments every cycle without `byte_valid` and clears on `byte_valid`. When it reaches `TIMEOUT_CYCLES-1` the parser returns to IDLE and rejects the frame. If a byte arrives in the same cycle as the terminal count, the byte wins: it is parsed and the counter clears.
- `busy` is high in CMD, DATA and CHK.

## Timing
- Reset values: `rden`, `reg_wr_en`, `start_o`, `stop_o` and `frame_err` are 0. `reg_addr`, `reg_wr_data`, `err_count` are 0. `busy` is 0 and the state is IDLE.
- Reset asserted mid-frame: the partial frame is dropped and a byte in flight from the FIFO is lost. No `frame_err` is raised.
- Latency: checksum byte `byte_valid` at cycle T gives the strobe or pulse in T+1.
- `reg_addr` and `reg_wr_data` are valid with `reg_wr_en` and hold until the next write.
- Minimum frame period is 7 cycles back-to-back. A following frame's sync byte may arrive in cycle T+1 while the previous frame executes.
- `rden` asserted while `rdfifo_empty` is high never happens.

## Configuration
- `HOST_CMD_CHECKSUM_EN` defined: 7-byte frame with checksum checking as above.
- `HOST_CMD_CHECKSUM_EN` undefined: 6-byte frame with no checksum byte and no CHK state. The frame executes in T+1 after the 4th data byte. Checksum errors cannot occur; the other rejection causes still apply.

## Structure
- Package `host_cmd_pkg` holds:
  - `SYNC_BYTE` (`0xA5`).
  - Opcode constants `OP_WRITE`, `OP_START`, `OP_STOP`.
  - The state enum IDLE/CMD/DATA/CHK.
- One sub-module, `host_cmd_timer`: the inter-byte timeout counter, with `clear`, `run` and `expired`.

## Test plan
- Write to reg 3: `A5 13 DE AD BE EF 31` → `reg_wr_en` once, `reg_addr=3`, `reg_wr_data=0xDEADBEEF`, one cycle after the last byte.
- Start then stop, back-to-back: `A5 20 00 00 00 00 20 A5 30 00 00 00 00 30` → `start_o` then `stop_o`, 7 cycles apart, no `frame_err`.
- Bad checksum: `A5 13 DE AD BE EF 00` → `frame_err` pulse, `err_count=1`, no `reg_wr_en`.
- Garbage then frame: `FF 00 A5 20 00 00 00 00 20` → leading bytes ignored silently, `start_o` fires.
- Timeout: `A5 13`, then `rdfifo_empty` held for 4096 cycles → `frame_err`, `busy=0`. A following valid frame executes normally.
- Reset mid-frame after `A5 13 DE`: all outputs go to 0 immediately; the next complete frame executes.
- 300 bad frames → `err_count=255`.

Source files
------------

// File: rtl/host_cmd_pkg.sv
// Shared constants and parser state encoding for the host command decoder.
package host_cmd_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;

  localparam logic [3:0] OP_WRITE = 4'h1;
  localparam logic [3:0] OP_START = 4'h2;
  localparam logic [3:0] OP_STOP  = 4'h3;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    DATA,
    CHK
  } state_t;

endpackage

// File: rtl/host_cmd_timer.sv
// Inter-byte timeout counter: counts cycles while run is high, cleared by clear,
// expired flags the terminal count in the same cycle it is reached.
module host_cmd_timer #(
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CW = ($clog2(TIMEOUT_CYCLES) < 1) ? 1 : $clog2(TIMEOUT_CYCLES);

  logic [CW-1:0] cnt_reg;

  assign expired = run && (cnt_reg == CW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (run) begin
      cnt_reg <= cnt_reg + CW'(1);
    end
  end

endmodule

// File: rtl/host_cmd_decoder.sv
// Frames the ft245 byte stream into command packets and executes good ones.
// HOST_CMD_CHECKSUM_EN: 7-byte frames with trailing XOR checksum; undefined: 6-byte frames.
module host_cmd_decoder
  import host_cmd_pkg::*;
#(
  parameter int REG_ADDR_WIDTH = 3,
  parameter int REG_WIDTH      = 32,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      rdfifo_empty,
  output logic                      rden,
  input  logic [7:0]                rddata,
  output logic                      reg_wr_en,
  output logic [REG_ADDR_WIDTH-1:0] reg_addr,
  output logic [REG_WIDTH-1:0]      reg_wr_data,
  output logic                      start_o,
  output logic                      stop_o,
  output logic                      frame_err,
  output logic [7:0]                err_count,
  output logic                      busy
);

  state_t      state_reg;
  logic        byte_valid_reg;
  logic [7:0]  cmd_reg;
  logic [31:0] data_reg;
  logic [1:0]  beat_reg;
`ifdef HOST_CMD_CHECKSUM_EN
  logic [7:0]  xor_reg;
`endif

  logic        expired;
  logic        timer_clear;
  logic        last_byte;
  logic        chk_ok;
  logic        addr_ok;
  logic [31:0] frame_word;
  logic        do_write;
  logic        do_start;
  logic        do_stop;
  logic        do_reject;

  // Reading is held off during reset so no byte is pulled and then dropped.
  assign rden = rst_n && !rdfifo_empty;
  assign busy = (state_reg != IDLE);

  assign timer_clear = byte_valid_reg || (state_reg == IDLE);

  host_cmd_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (timer_clear),
    .run    (!timer_clear),
    .expired(expired)
  );

  always_comb begin
    frame_word = data_reg;
`ifdef HOST_CMD_CHECKSUM_EN
    last_byte = byte_valid_reg && (state_reg == CHK);
    chk_ok    = (rddata == xor_reg);
`else
    // Without a checksum the 4th data byte completes the frame in flight.
    last_byte  = byte_valid_reg && (state_reg == DATA) && (beat_reg == 2'd3);
    chk_ok     = 1'b1;
    frame_word = {data_reg[23:0], rddata};
`endif
    addr_ok   = ((cmd_reg[3:0] >> REG_ADDR_WIDTH) == 4'd0);
    do_write  = last_byte && chk_ok && (cmd_reg[7:4] == OP_WRITE) && addr_ok;
    do_start  = last_byte && chk_ok && (cmd_reg[7:4] == OP_START);
    do_stop   = last_byte && chk_ok && (cmd_reg[7:4] == OP_STOP);
    do_reject = expired || (last_byte && !(do_write || do_start || do_stop));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg      <= IDLE;
      byte_valid_reg <= 1'b0;
      cmd_reg        <= '0;
      data_reg       <= '0;
      beat_reg       <= '0;
`ifdef HOST_CMD_CHECKSUM_EN
      xor_reg        <= '0;
`endif
      reg_wr_en      <= 1'b0;
      reg_addr       <= '0;
      reg_wr_data    <= '0;
      start_o        <= 1'b0;
      stop_o         <= 1'b0;
      frame_err      <= 1'b0;
      err_count      <= '0;
    end else begin
      byte_valid_reg <= rden;
      reg_wr_en      <= do_write;
      start_o        <= do_start;
      stop_o         <= do_stop;
      frame_err      <= do_reject;
      if (do_write) begin
        reg_addr    <= REG_ADDR_WIDTH'(cmd_reg[3:0]);
        reg_wr_data <= REG_WIDTH'(frame_word);
      end
      if (do_reject && (err_count != 8'hFF)) begin
        err_count <= err_count + 8'd1;
      end

      if (expired) begin
        state_reg <= IDLE;
      end else if (byte_valid_reg) begin
        case (state_reg)
          IDLE: begin
            if (rddata == SYNC_BYTE) state_reg <= CMD;
          end
          CMD: begin
            cmd_reg   <= rddata;
`ifdef HOST_CMD_CHECKSUM_EN
            xor_reg   <= rddata;
`endif
            beat_reg  <= 2'd0;
            state_reg <= DATA;
          end
          DATA: begin
            data_reg <= {data_reg[23:0], rddata};
`ifdef HOST_CMD_CHECKSUM_EN
            xor_reg  <= xor_reg ^ rddata;
`endif
            beat_reg <= beat_reg + 2'd1;
            if (beat_reg == 2'd3) begin
`ifdef HOST_CMD_CHECKSUM_EN
              state_reg <= CHK;
`else
              state_reg <= IDLE;
`endif
            end
          end
          default: state_reg <= IDLE;
        endcase
      end
    end
  end

endmodule
